nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequences one shared 4-bit ripple-carry slice to add or subtract WIDTH-bit operands,
//  one nibble per clock, LSB nibble first, carrying between nibbles in a register.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
//  Trades latency (WIDTH/4 cycles) for area: one 4-bit adder serves any operand width.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 4
//  NSLICES  WIDTH/4  derived localparam: nibble iterations per operation
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand beat (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: A+B, 1: A-B (two's complement)
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, registered
//  cout       out  1      final carry; for sub, 1 = no borrow (A >= B unsigned)
//  busy       out  1      high in RUN or DONE
//  ovf        out  1      signed overflow; present only with NSA_OVERFLOW_EN
// BEHAVIOUR
//  Reset (rst_n low, any state): state=IDLE; sum=0, cout=0, out_valid=0, busy=0, ovf=0,
//   in_ready=1 once reset released; operation in flight is discarded, no partial result.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready: latch a, b^{WIDTH{sub}}, carry=sub, idx=0,
//   clear sum register -> RUN.
//  RUN: each cycle slice computes a[idx*4+:4] + b_lat[idx*4+:4] + carry; nibble written
//   to sum[idx*4+:4], carry updated, idx++. After the idx=NSLICES-1 edge -> DONE,
//   cout=final carry. in_ready=0, in_valid ignored.
//  DONE: out_valid=1; sum/cout stable until out_valid&out_ready -> IDLE.
//  Latency: out_valid rises exactly NSLICES cycles after the accept edge (WIDTH=4: 1 cycle).
//  Throughput: at most one op per NSLICES+2 cycles; in_ready stays 0 in the DONE
//   handshake cycle even if in_valid is high, so a new op is accepted the next cycle.
//  Arithmetic is modulo 2^WIDTH; carry out of the top nibble goes only to cout.
//  sum is visible (partial) during RUN but meaningful only while out_valid=1.
//  idx counter width $clog2(NSLICES) (min 1); no wrap: FSM exits RUN before overflow.
// CONFIGURATION
//  NSA_OVERFLOW_EN defined: extra output ovf, registered with cout at RUN->DONE,
//   ovf = carry into MSB XOR carry out of MSB (slice exposes MSB carry-in); held with sum.
//  NSA_OVERFLOW_EN undefined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//  Package nsa_pkg: state enum nsa_state_t {IDLE, RUN, DONE}; localparam NIBBLE=4.
//  Sub-module nibble_adder: combinational 4-bit ripple slice (a, b, cin -> s, cout,
//   c_msb_in), instantiated once; controller holds FSM, idx, carry, operand and sum regs.
// TESTING (WIDTH=16 unless noted)
//  0x1234 + 0x0FFF, sub=0 -> sum=0x2233, cout=0, out_valid exactly 4 cycles after accept.
//  0xFFFF + 0x0001, sub=0 -> sum=0x0000, cout=1; with NSA_OVERFLOW_EN ovf=0.
//  0x0005 - 0x0007, sub=1 -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> 0x0002, cout=1.
//  0x7FFF + 0x0001 with NSA_OVERFLOW_EN -> sum=0x8000, cout=0, ovf=1.
//  out_ready low 10 cycles in DONE, in_valid high -> sum/cout stable, in_ready=0 throughout.
//  rst_n low during RUN idx=2, then high -> outputs 0, IDLE; next op 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types for the nibble-serial adder controller.
// Optional signed-overflow output is enabled by defining NSA_OVERFLOW_EN.
package nsa_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int NIBBLE = 4;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// ovf exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();
  // Both sides: a beat transfers on the rising edge where valid && ready;
  // a raised valid and its payload hold until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
`ifdef NSA_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
`ifdef NSA_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple slice; also exposes the carry into its MSB
// so the controller can derive signed overflow on the top nibble.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c_msb_in
);
  logic [4:0] full;
  logic [3:0] low3;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    low3     = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, cin};
    s        = full[3:0];
    cout     = full[4];
    c_msb_in = low3[3];
  end
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/subtract WIDTH-bit operands one nibble per clock through a single 4-bit slice.
// Define NSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_adder_ctrl_if.slave bus,
  output nsa_state_t                dbg_state
);
  localparam int NSLICES = WIDTH / NIBBLE;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  nsa_state_t       state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q;
  logic             accept;
  logic             last_nibble;

  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_co;
`ifdef NSA_OVERFLOW_EN
  logic             slice_cmsb;
  logic             ovf_q;
`else
  logic             unused_slice_cmsb;
`endif

  assign slice_a     = a_q[idx_q*NIBBLE +: NIBBLE];
  assign slice_b     = b_q[idx_q*NIBBLE +: NIBBLE];
  assign accept      = bus.in_valid && bus.in_ready;
  assign last_nibble = (idx_q == LAST_IDX);

  nibble_adder u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_q),
    .s        (slice_s),
    .cout     (slice_co),
`ifdef NSA_OVERFLOW_EN
    .c_msb_in (slice_cmsb)
`else
    .c_msb_in (unused_slice_cmsb)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nibble) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at accept and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b ^ {WIDTH{bus.sub}};
        carry_q <= bus.sub;
        idx_q   <= '0;
        sum_q   <= '0;
      end
    end else if (state_q == RUN) begin
      sum_q[idx_q*NIBBLE +: NIBBLE] <= slice_s;
      carry_q <= slice_co;
      if (last_nibble) begin
        cout_q <= slice_co;
`ifdef NSA_OVERFLOW_EN
        ovf_q  <= slice_co ^ slice_cmsb;
`endif
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16); ovf checks follow NSA_OVERFLOW_EN.
module tb_nibble_serial_adder_ctrl;
  import nsa_pkg::*;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  nsa_state_t dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [W+1:0] exp_q[$];  // {ovf, cout, sum}

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    check_val("accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check_val({tag, "_latency"}, 32'(cnt), 32'(LAT));
  endtask

  task automatic score(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_sum"}, 32'(bus.sum), 32'(e[W-1:0]));
      check_val({tag, "_cout"}, 32'(bus.cout), 32'(e[W]));
`ifdef NSA_OVERFLOW_EN
      check_val({tag, "_ovf"}, 32'(bus.ovf), 32'(e[W+1]));
`endif
    end
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_ir_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_q.push_back({eo, ec, es});
    start_op(a, b, sub);
    wait_result(tag);
    score(tag);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_val({tag, "_ir_done"}, 32'(bus.in_ready), 32'd0);
    release_result(tag);
  endtask

  // ---------------- stimulus
  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_cout", 32'(bus.cout), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef NSA_OVERFLOW_EN
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);

    //      tag       a        b        sub   sum      cout  ovf
    do_op("add_a", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op("add_wr", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("add_alt", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    do_op("sub_eq", 16'h3C3C, 16'h3C3C, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Hold the result in DONE with a competing operand offered.
    exp_q.push_back({1'b0, 1'b0, 16'h2233});
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_result("hold");
    bus.a        = 16'h0001;
    bus.b        = 16'h0002;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold_sum", 32'(bus.sum), 32'h2233);
      check_val("hold_cout", 32'(bus.cout), 32'd0);
      check_val("hold_ov", 32'(bus.out_valid), 32'd1);
      check_val("hold_ir", 32'(bus.in_ready), 32'd0);
    end
    score("hold");
    bus.out_ready = 1'b1;
    check_val("hs_ir_low", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    check_val("post_hs_ir", 32'(bus.in_ready), 32'd1);
    check_val("post_hs_ov", 32'(bus.out_valid), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 16'h0003});
    tick();
    bus.in_valid = 1'b0;
    wait_result("b2b");
    score("b2b");
    release_result("b2b");

    // Reset mid-operation with idx at 2.
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    check_val("mid_state", 32'(dbg_state), 32'(RUN));
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sum", 32'(bus.sum), 32'd0);
    check_val("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    #1;
    check_val("mid_rel_ir", 32'(bus.in_ready), 32'd1);
    check_val("mid_rel_ov", 32'(bus.out_valid), 32'd0);
    tick();
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // ---------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
